cam_chan_avg: RTL and testbench

- Multi-channel per-frame pixel averager for the camera/VGA path.
- Accumulates NUM_CH pixel channels during active video and snapshots the sums at each frame end.
- Divides each sum by the pixel count with a shared sequential divider, so accumulation of the next frame continues during the divide.
- Emits one averaged colour per FRAME_DIV frames, with a valid pulse plus a legacy toggle.

---
 rtl/cam_avg_pkg.sv | 26 ++
 rtl/cam_chan_avg_seq_divider.sv | 62 ++++++
 rtl/cam_chan_avg.sv | 201 ++++++++++++++++++++
 tb/tb_cam_chan_avg.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cam_avg_pkg.sv
// Shared types and defaults for the per-frame channel averager.
// State encoding, channel-index width helper and default widths live here
// so the top and the divider agree on them.
package cam_avg_pkg;

  // Result-path state: waiting, dividing channel by channel, publishing.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } avg_state_e;

  localparam int DEF_NUM_CH = 3;
  localparam int DEF_PIX_W  = 8;
  localparam int DEF_ACC_W  = 32;
  // Frame counter width; covers FRAME_DIV up to 255.
  localparam int FCNT_W     = 8;

  // Width of a channel index; never below one bit so a single channel
  // still gets a legal vector.
  function automatic int ch_idx_w(input int num_ch);
    if (num_ch <= 1) return 1;
    return $clog2(num_ch);
  endfunction

endpackage

// File: rtl/cam_chan_avg_seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
// Handshake: start is a one-cycle strobe that samples dividend and already
// performs the first step; done is high in the cycle that performs the last
// (ACC_W-th) step, and quotient is valid only while done is high. divisor
// must stay stable from start through done. A start while running restarts.
module seq_divider
  import cam_avg_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             VGA_CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [ACC_W-1:0] dividend,
  input  logic [ACC_W-1:0] divisor,
  output logic             done,
  output logic [ACC_W-1:0] quotient
);

  localparam int CNT_W = $clog2(ACC_W);

  logic [ACC_W-1:0] rem_q, quo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             active_q;

  logic [ACC_W-1:0] rem_in, quo_in, rem_nx, quo_nx;
  logic [CNT_W-1:0] cnt_in;
  logic [ACC_W+1:0] trial;
  logic             ge;
  logic             unused_trial;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_in = start ? '0 : rem_q;
    quo_in = start ? dividend : quo_q;
    cnt_in = start ? '0 : cnt_q;
    trial  = {1'b0, rem_in, quo_in[ACC_W-1]} - {2'b00, divisor};
    ge     = ~trial[ACC_W+1];
    rem_nx = ge ? trial[ACC_W-1:0] : {rem_in[ACC_W-2:0], quo_in[ACC_W-1]};
    quo_nx = {quo_in[ACC_W-2:0], ge};
  end

  assign unused_trial = trial[ACC_W];
  assign done     = (start | active_q) & (cnt_in == CNT_W'(ACC_W - 1));
  assign quotient = quo_nx;

  // Step registers advance only while a division is in flight.
  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST) begin
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start | active_q) begin
      rem_q    <= rem_nx;
      quo_q    <= quo_nx;
      cnt_q    <= cnt_in + CNT_W'(1);
      active_q <= ~done;
    end
  end

endmodule

// File: rtl/cam_chan_avg.sv
// Per-frame multi-channel pixel averager for the camera/VGA path.
// Sums each channel over active video, snapshots at frame end (falling
// V_SYNC) and divides by the pixel count on one shared sequential divider
// while the next frame keeps accumulating.
// Optional build macro CAM_AVG_ROI_EN restricts accumulation to a
// rectangular region of interest given by the ROI_* parameters.
module cam_chan_avg
  import cam_avg_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int PIX_W     = DEF_PIX_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int FRAME_DIV = 1,
  parameter int ROI_X0    = 0,
  parameter int ROI_X1    = 640,
  parameter int ROI_Y0    = 0,
  parameter int ROI_Y1    = 480
) (
  input  logic                    VGA_CLK,
  input  logic                    RST,
  input  logic                    V_SYNC,
  input  logic                    pix_valid,
  input  logic [NUM_CH*PIX_W-1:0] pixel,
  output logic [NUM_CH*PIX_W-1:0] avg,
  output logic                    avg_valid,
  output logic                    upd,
  output logic                    busy,
  output logic                    overrun
);

  localparam int                CH_W       = ch_idx_w(NUM_CH);
  localparam logic [CH_W-1:0]   CH_LAST    = CH_W'(NUM_CH - 1);
  localparam logic [FCNT_W-1:0] FRAME_LAST = FCNT_W'(FRAME_DIV - 1);

  logic                          vs_q, fe, roi_ok, acc_en, req;
  logic [NUM_CH-1:0][ACC_W-1:0]  acc_q, acc_nx, op_acc_q;
  logic [NUM_CH-1:0][ACC_W:0]    acc_sum;
  logic [ACC_W-1:0]              cnt_q, cnt_nx, op_cnt_q;
  logic [ACC_W:0]                cnt_sum;
  logic [FCNT_W-1:0]             fcnt_q;
  avg_state_e                    state_q, state_d;
  logic [CH_W-1:0]               ch_q;
  logic                          first_q;
  logic [NUM_CH-1:0][PIX_W-1:0]  quo_q;
  logic                          div_start, div_done;
  logic [ACC_W-1:0]              div_quo;
  logic [ACC_W-PIX_W-1:0]        unused_div_hi;

`ifdef CAM_AVG_ROI_EN
  localparam logic [31:0] X0 = ROI_X0;
  localparam logic [31:0] X1 = ROI_X1;
  localparam logic [31:0] Y0 = ROI_Y0;
  localparam logic [31:0] Y1 = ROI_Y1;
  logic [31:0] x_q, y_q;
  logic        pv_q;

  // Column counter restarts per line; line counter advances on each line end.
  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST) begin
      x_q  <= '0;
      y_q  <= '0;
      pv_q <= 1'b0;
    end else if (!V_SYNC) begin
      x_q  <= '0;
      y_q  <= '0;
      pv_q <= 1'b0;
    end else begin
      pv_q <= pix_valid;
      x_q  <= pix_valid ? x_q + 32'd1 : '0;
      if (pv_q && !pix_valid) y_q <= y_q + 32'd1;
    end
  end

  assign roi_ok = (x_q >= X0) && (x_q < X1) && (y_q >= Y0) && (y_q < Y1);
`else
  logic unused_roi;
  assign unused_roi = ^{ROI_X0[0], ROI_X1[0], ROI_Y0[0], ROI_Y1[0]};
  assign roi_ok     = 1'b1;
`endif

  assign fe     = vs_q & ~V_SYNC;
  assign acc_en = V_SYNC & pix_valid & roi_ok;
  assign req    = fe & (fcnt_q == FRAME_LAST);
  assign busy   = (state_q != IDLE);

  // Saturating next values for every channel sum and the pixel count.
  always_comb begin
    acc_sum = '0;
    acc_nx  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      acc_sum[c] = {1'b0, acc_q[c]} + (ACC_W + 1)'(pixel[c*PIX_W +: PIX_W]);
      acc_nx[c]  = acc_sum[c][ACC_W] ? '1 : acc_sum[c][ACC_W-1:0];
    end
    cnt_sum = {1'b0, cnt_q} + (ACC_W + 1)'(1);
    cnt_nx  = cnt_sum[ACC_W] ? '1 : cnt_sum[ACC_W-1:0];
  end

  // Frame-sync delay used for falling-edge detection.
  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST) vs_q <= 1'b0;
    else     vs_q <= V_SYNC;
  end

  // Accumulate during active video; blanking (V_SYNC low) clears.
  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (!V_SYNC) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (acc_en) begin
      acc_q <= acc_nx;
      cnt_q <= cnt_nx;
    end
  end

  // Frame decimation: only every FRAME_DIV-th frame end requests a result.
  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST)                        fcnt_q <= '0;
    else if (fe && fcnt_q == FRAME_LAST) fcnt_q <= '0;
    else if (fe)                    fcnt_q <= fcnt_q + FCNT_W'(1);
  end

  // State register of the result path.
  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and divider start; an empty frame skips the divide.
  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    case (state_q)
      IDLE: if (req) state_d = (cnt_q != '0) ? DIV : DONE;
      DIV: begin
        div_start = first_q;
        if (div_done && ch_q == CH_LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand snapshot, per-channel quotient capture, result publication.
  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST) begin
      op_acc_q  <= '0;
      op_cnt_q  <= '0;
      ch_q      <= '0;
      first_q   <= 1'b0;
      quo_q     <= '0;
      avg       <= '0;
      avg_valid <= 1'b0;
      upd       <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (req) begin
        if (state_q == IDLE) begin
          op_acc_q <= acc_q;
          op_cnt_q <= cnt_q;
          ch_q     <= '0;
          first_q  <= 1'b1;
          if (cnt_q == '0) quo_q <= '0;
        end else begin
          overrun <= 1'b1;
        end
      end
      if (state_q == DIV) begin
        if (div_start) first_q <= 1'b0;
        if (div_done) begin
          quo_q[ch_q] <= div_quo[PIX_W-1:0];
          ch_q        <= ch_q + CH_W'(1);
          first_q     <= 1'b1;
        end
      end
      if (state_q == DONE) begin
        avg       <= quo_q;
        avg_valid <= 1'b1;
        upd       <= ~upd;
      end
    end
  end

  assign unused_div_hi = div_quo[ACC_W-1:PIX_W];

  seq_divider #(
    .ACC_W (ACC_W)
  ) u_div (
    .VGA_CLK  (VGA_CLK),
    .RST      (RST),
    .start    (div_start),
    .dividend (op_acc_q[ch_q]),
    .divisor  (op_cnt_q),
    .done     (div_done),
    .quotient (div_quo)
  );

endmodule

// File: tb/tb_cam_chan_avg.sv
// Directed bench for cam_chan_avg. dut0 runs FRAME_DIV=1, dut1 FRAME_DIV=4;
// with CAM_AVG_ROI_EN defined, dut2 adds a 2..3 x 1..3 region of interest.
module tb_cam_chan_avg;

  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst;
  logic         v_sync;
  logic         pix_valid;
  logic [W-1:0] pixel;

  logic [W-1:0] avg0, avg1;
  logic         avg_valid0, upd0, busy0, overrun0;
  logic         avg_valid1, upd1, busy1, overrun1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  int           lat0, n0, n1;
  logic         busy_first, busy_at_valid;
  logic [W-1:0] avg1_last;

  always #5 clk = ~clk;

  cam_chan_avg u_dut0 (
    .VGA_CLK(clk), .RST(rst), .V_SYNC(v_sync), .pix_valid(pix_valid),
    .pixel(pixel), .avg(avg0), .avg_valid(avg_valid0), .upd(upd0),
    .busy(busy0), .overrun(overrun0)
  );

  cam_chan_avg #(.FRAME_DIV(4)) u_dut1 (
    .VGA_CLK(clk), .RST(rst), .V_SYNC(v_sync), .pix_valid(pix_valid),
    .pixel(pixel), .avg(avg1), .avg_valid(avg_valid1), .upd(upd1),
    .busy(busy1), .overrun(overrun1)
  );

`ifdef CAM_AVG_ROI_EN
  logic [W-1:0] avg2, avg2_last;
  logic         avg_valid2, upd2, busy2, overrun2;
  int           n2;

  cam_chan_avg #(.ROI_X0(2), .ROI_X1(4), .ROI_Y0(1), .ROI_Y1(4)) u_dut2 (
    .VGA_CLK(clk), .RST(rst), .V_SYNC(v_sync), .pix_valid(pix_valid),
    .pixel(pixel), .avg(avg2), .avg_valid(avg_valid2), .upd(upd2),
    .busy(busy2), .overrun(overrun2)
  );
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every dut0 result must match the oldest expected average.
  always @(negedge clk) begin
    if (!rst && avg_valid0 === 1'b1) begin
      if (exp_q.size() == 0) check("sb_extra_result", 64'(exp_q.size()), 64'd1);
      else                   check("sb_avg", 64'(avg0), 64'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_start();
    v_sync = 1'b1;
    repeat (2) tick();
  endtask

  task automatic send_pix(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
    pixel     = {c2, c1, c0};
    pix_valid = 1'b1;
    tick();
  endtask

  task automatic end_line();
    pix_valid = 1'b0;
    pixel     = '0;
    tick();
  endtask

  // Drop V_SYNC and watch outputs for a bounded number of edges.
  task automatic fe_wait(input int budget);
    v_sync = 1'b0;
    lat0 = -1; n0 = 0; n1 = 0;
    busy_first = 1'b0; busy_at_valid = 1'b1;
`ifdef CAM_AVG_ROI_EN
    n2 = 0;
`endif
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (i == 1) busy_first = busy0;
      if (avg_valid0) begin
        n0++;
        if (lat0 < 0) begin
          lat0 = i;
          busy_at_valid = busy0;
        end
      end
      if (avg_valid1) begin
        n1++;
        avg1_last = avg1;
      end
`ifdef CAM_AVG_ROI_EN
      if (avg_valid2) begin
        n2++;
        avg2_last = avg2;
      end
`endif
    end
  endtask

  initial begin
    int cnt;
    rst = 1'b1; v_sync = 1'b1; pix_valid = 1'b0; pixel = '0;

    // Reset values
    repeat (3) tick();
    check("rst_avg", 64'(avg0), 64'd0);
    check("rst_avg_valid", 64'(avg_valid0), 64'd0);
    check("rst_upd", 64'(upd0), 64'd0);
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_overrun", 64'(overrun0), 64'd0);
    rst = 1'b0;
    repeat (5) tick();
    check("idle_avg", 64'(avg0), 64'd0);
    check("idle_avg_valid", 64'(avg_valid0), 64'd0);
    check("idle_upd", 64'(upd0), 64'd0);
    check("idle_busy", 64'(busy0), 64'd0);
    check("idle_overrun", 64'(overrun0), 64'd0);

    // Basic: 100 pixels -> 4950/100=49, 200, 20550/100=205
    exp_q.push_back({8'd205, 8'd200, 8'd49});
    frame_start();
    for (int i = 0; i < 100; i++) send_pix(8'(i), 8'd200, 8'(255 - i));
    end_line();
    fe_wait(110);
    check("basic_latency", 64'(lat0), 64'd98);
    check("basic_count", 64'(n0), 64'd1);
    check("basic_busy_run", 64'(busy_first), 64'd1);
    check("basic_busy_end", 64'(busy_at_valid), 64'd0);
    check("basic_upd", 64'(upd0), 64'd1);
    check("basic_avg", 64'(avg0), 64'({8'd205, 8'd200, 8'd49}));
    check("basic_pulse_low", 64'(avg_valid0), 64'd0);

    // Empty frame: result after 2 cycles, all zero
    exp_q.push_back('0);
    frame_start();
    repeat (3) tick();
    fe_wait(10);
    check("empty_latency", 64'(lat0), 64'd2);
    check("empty_avg", 64'(avg0), 64'd0);
    check("empty_overrun", 64'(overrun0), 64'd0);
    check("empty_upd", 64'(upd0), 64'd0);

    // Overrun: 36/4=9, 10/4=2 (truncated), 255; second fe 10 cycles later
    exp_q.push_back({8'd255, 8'd2, 8'd9});
    frame_start();
    send_pix(8'd6, 8'd1, 8'd255);
    send_pix(8'd8, 8'd2, 8'd255);
    send_pix(8'd10, 8'd3, 8'd255);
    send_pix(8'd12, 8'd4, 8'd255);
    end_line();
    v_sync = 1'b0;
    repeat (3) tick();
    v_sync = 1'b1;
    repeat (7) tick();
    fe_wait(110);
    check("ovr_latency", 64'(lat0), 64'd88);
    check("ovr_count", 64'(n0), 64'd1);
    check("ovr_flag", 64'(overrun0), 64'd1);
    repeat (20) tick();
    check("ovr_sticky", 64'(overrun0), 64'd1);

    // Reset 20 cycles into a divide: no result
    frame_start();
    send_pix(8'd50, 8'd60, 8'd70);
    send_pix(8'd52, 8'd62, 8'd72);
    end_line();
    v_sync = 1'b0;
    repeat (20) tick();
    rst = 1'b1;
    repeat (3) tick();
    check("midrst_avg", 64'(avg0), 64'd0);
    check("midrst_busy", 64'(busy0), 64'd0);
    check("midrst_overrun", 64'(overrun0), 64'd0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (avg_valid0) cnt++;
    end
    check("midrst_no_result", 64'(cnt), 64'd0);

    // Decimation on dut1: only the 4th frame (ch0=40) is reported
    for (int f = 0; f < 4; f++) begin
      exp_q.push_back({8'd0, 8'd0, 8'(10 * (f + 1))});
      frame_start();
      for (int k = 0; k < 5; k++) send_pix(8'(10 * (f + 1)), 8'd0, 8'd0);
      end_line();
      fe_wait(110);
      if (f < 3) check($sformatf("dec_none_f%0d", f), 64'(n1), 64'd0);
      else begin
        check("dec_one", 64'(n1), 64'd1);
        check("dec_avg", 64'(avg1_last), 64'({8'd0, 8'd0, 8'd40}));
        check("dec_upd", 64'(upd1), 64'd1);
      end
    end

`ifdef CAM_AVG_ROI_EN
    // ROI: x+10*y over 6x5; ROI mean = 135/6 = 22, full frame 675/30 = 22
    exp_q.push_back({8'd0, 8'd0, 8'd22});
    frame_start();
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 6; x++) send_pix(8'(x + 10 * y), 8'd0, 8'd0);
      end_line();
      tick();
    end
    fe_wait(110);
    check("roi_count", 64'(n2), 64'd1);
    check("roi_avg", 64'(avg2_last), 64'({8'd0, 8'd0, 8'd22}));
`endif

    repeat (5) tick();
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
